// File: rtl/seq_link_pkg.sv
// Shared definitions for the 1101-marker serial link.
// Used by both the transmitter and the receive-side detector.
package seq_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_STUFF,
        ST_GAP
    } link_state_e;

    localparam int         PRE_LEN  = 4;
    localparam logic [3:0] PREAMBLE = 4'b1101;
    localparam logic [1:0] RUN_MAX  = 2'd2;

    function automatic logic pre_bit(input logic [1:0] idx);
        return PREAMBLE[2'd3 - idx];
    endfunction

endpackage

// File: rtl/seq_frame_tx_if.sv
// Word handshake plus serial line bundle of the frame transmitter.
// master drives words in, slave is the transmitter.
interface seq_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out;
    logic              out_valid;
    logic              frame_done;
    logic              busy;

    modport master (
        output in_valid, in_data,
        input  in_ready, out, out_valid, frame_done, busy
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, out, out_valid, frame_done, busy
    );
endinterface

// File: rtl/seq_piso_shift.sv
// Parallel-in serial-out register, MSB first.
// Load has priority over shift.
module seq_piso_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              msb_o
);
    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = sr_q << 1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb_o = sr_q[DATA_W-1];
endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: 1101 preamble, zero-stuffed payload, idle gap.
// Every output is registered; the comb block decides next cycle's line bit.
module seq_frame_tx
    import seq_link_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int GAP_LEN = 2
) (
    input logic           clk,
    input logic           reset,
    seq_frame_tx_if.slave bus
);
    localparam int BW = $clog2(DATA_W + 1);
    localparam int GW = $clog2(GAP_LEN + 1);

    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LEN);
    localparam logic [1:0]    PRE_LAST = 2'(PRE_LEN - 1);

    link_state_e   state_q, state_d;
    logic [1:0]    pre_q, pre_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [1:0]    run_q, run_d;
    logic          stf_q, stf_d;
    logic          out_q, out_d;
    logic          vld_q, vld_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          rdy_q, rdy_d;

    logic       accept;
    logic       emit;
    logic       to_gap;
    logic [1:0] run_base;
    logic       sr_load;
    logic       sr_shift;
    logic       sr_msb;

    assign accept = bus.in_valid & rdy_q;

    seq_piso_shift #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk     (clk),
        .reset   (reset),
        .load_i  (sr_load),
        .shift_i (sr_shift),
        .data_i  (bus.in_data),
        .msb_o   (sr_msb)
    );

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        run_d    = run_q;
        stf_d    = stf_q;
        out_d    = 1'b0;
        done_d   = 1'b0;
        emit     = 1'b0;
        to_gap   = 1'b0;
        run_base = run_q;
        sr_load  = 1'b0;
        sr_shift = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_PRE;
                    pre_d   = 2'd0;
                    bit_d   = '0;
                    sr_load = 1'b1;
                    out_d   = pre_bit(2'd0);
                end
            end
            ST_PRE: begin
                if (pre_q == PRE_LAST) begin
                    // preamble ends in a 1, so the run starts at one
                    emit     = 1'b1;
                    run_base = 2'd1;
                end else begin
                    pre_d = pre_q + 2'd1;
                    out_d = pre_bit(pre_q + 2'd1);
                end
            end
            ST_DATA: begin
                if (run_q == RUN_MAX) begin
                    state_d = ST_STUFF;
                    stf_d   = 1'b0;
                    run_d   = 2'd0;
                end else if (bit_q == BIT_LAST) begin
                    to_gap = 1'b1;
                end else begin
                    emit = 1'b1;
                end
            end
            ST_STUFF: begin
                if (!stf_q) begin
                    stf_d = 1'b1;
                end else if (bit_q == BIT_LAST) begin
                    to_gap = 1'b1;
                end else begin
                    emit = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (emit) begin
            state_d  = ST_DATA;
            sr_shift = 1'b1;
            out_d    = sr_msb;
            bit_d    = bit_q + BW'(1);
            run_d    = sr_msb ? run_base + 2'd1 : 2'd0;
        end

        if (to_gap) begin
            state_d = ST_GAP;
            gap_d   = GW'(1);
            done_d  = 1'b1;
        end

        vld_d  = (state_d == ST_PRE) || (state_d == ST_DATA)
              || (state_d == ST_STUFF);
        busy_d = (state_d != ST_IDLE);
        rdy_d  = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pre_q   <= 2'd0;
            bit_q   <= '0;
            gap_q   <= '0;
            run_q   <= 2'd0;
            stf_q   <= 1'b0;
            out_q   <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            run_q   <= run_d;
            stf_q   <= stf_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.out        = out_q;
    assign bus.out_valid  = vld_q;
    assign bus.frame_done = done_q;
    assign bus.busy       = busy_q;
    assign bus.in_ready   = rdy_q;
endmodule
